// File: rtl/seq_mult_pkg.sv
// Purpose: shared sizes and FSM encoding for the sequential shift-add multiplier.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package seq_mult_pkg;

    // Operand width; fixed to the width of the CLA adder.
    localparam int WIDTH = 16;
    // Bit counter width; must hold the value WIDTH, not only WIDTH-1.
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_16bit.sv
// Purpose: 16-bit carry-lookahead adder, four 4-bit groups with a second lookahead level.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module cla_16bit (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] s_o,
    output logic        cout_o
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Group-level lookahead: carry into each 4-bit group from group generate/propagate.
    assign gc[0] = cin_i;
    assign gc[1] = gg[0] | (gp[0] & cin_i);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin_i);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & cin_i);
    assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0])
                 | (gp[3] & gp[2] & gp[1] & gp[0] & cin_i);

    for (genvar k = 0; k < 4; k++) begin : g_grp
        logic [3:0] gk;
        logic [3:0] pk;
        logic       ck;

        assign gk = g[4*k +: 4];
        assign pk = p[4*k +: 4];
        assign ck = gc[k];

        assign gg[k] = gk[3] | (pk[3] & gk[2]) | (pk[3] & pk[2] & gk[1])
                     | (pk[3] & pk[2] & pk[1] & gk[0]);
        assign gp[k] = &pk;

        // Bit carries inside the group, each fully expanded from the group carry-in.
        assign c[4*k]     = ck;
        assign c[4*k + 1] = gk[0] | (pk[0] & ck);
        assign c[4*k + 2] = gk[1] | (pk[1] & gk[0]) | (pk[1] & pk[0] & ck);
        assign c[4*k + 3] = gk[2] | (pk[2] & gk[1]) | (pk[2] & pk[1] & gk[0])
                          | (pk[2] & pk[1] & pk[0] & ck);
    end

    assign s_o    = p ^ c;
    assign cout_o = gc[4];

endmodule

// File: rtl/seq_mult_16bit.sv
// Purpose: unsigned 16x16->32 shift-add multiplier, one multiplier bit retired per cycle.
// Latency: accept at edge T, out_valid from edge T+17; one transaction in flight.
// Backpressure: holds product/out_valid indefinitely while out_ready=0; in_ready only in IDLE.
module seq_mult_16bit
    import seq_mult_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    state_t                state_q;
    logic [WIDTH-1:0]      md_q;
    logic [WIDTH-1:0]      mq_q;
    logic [WIDTH-1:0]      acc_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [2*WIDTH-1:0]    product_q;
    logic                  out_valid_q;
    logic                  busy_q;

    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_s;
    logic                  add_cout;
    logic [WIDTH-1:0]      acc_d;
    logic [WIDTH-1:0]      mq_d;

    // Partial product is the multiplicand only when the current multiplier bit is set.
    assign add_a = mq_q[0] ? md_q : '0;

    cla_16bit u_cla (
        .a_i    (add_a),
        .b_i    (acc_q),
        .cin_i  (1'b0),
        .s_o    (add_s),
        .cout_o (add_cout)
    );

    // 33-bit {cout,sum,mq} shifted right by one into the 32-bit {acc,mq} pair.
    assign acc_d = {add_cout, add_s[WIDTH-1:1]};
    assign mq_d  = {add_s[0], mq_q[WIDTH-1:1]};

    // Reset dominates so no operand is ever advertised as accepted in a reset cycle.
    assign in_ready  = !rst && (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign busy      = busy_q;

    // Control FSM plus datapath registers; cnt runs 0..WIDTH, the final RUN cycle publishes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            md_q        <= '0;
            mq_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        md_q    <= a;
                        mq_q    <= b;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cnt_q == CNT_W'(WIDTH)) begin
                        product_q   <= {acc_q, mq_q};
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        acc_q <= acc_d;
                        mq_q  <= mq_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
